// File: rtl/memory.sv
// Single-port synchronous RAM with registered read data, a one-cycle read
// valid flag, and a registered bypass path when the enable is low.
module memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  memory_clk,
    input  logic                  memory_rst,
    input  logic                  memory_en,
    input  logic                  memory_wr,
    input  logic [ADDR_WIDTH-1:0] memory_addr,
    input  logic [DATA_WIDTH-1:0] memory_data_in,
    output logic                  memory_vld_out,
    output logic [DATA_WIDTH-1:0] memory_data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset clears every word, so the array is built from flops rather than
    // a RAM macro; one operation is resolved per edge in priority order.
    always_ff @(posedge memory_clk) begin
        if (memory_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            memory_data_out <= '0;
            memory_vld_out  <= 1'b0;
        end else if (!memory_en) begin
            memory_data_out <= memory_data_in;
            memory_vld_out  <= 1'b0;
        end else if (memory_wr) begin
            mem[memory_addr] <= memory_data_in;
            memory_vld_out   <= 1'b0;
        end else begin
            memory_data_out <= mem[memory_addr];
            memory_vld_out  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed plus randomized bench for memory, checked against a behavioural
// array model of the RAM and its output register.
module tb_memory;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic          vld;
    logic [DW-1:0] dout;

    int compared = 0;
    int mismatched = 0;

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out;
    logic          ref_vld;

    memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .memory_clk      (clk),
        .memory_rst      (rst),
        .memory_en       (en),
        .memory_wr       (wr),
        .memory_addr     (addr),
        .memory_data_in  (din),
        .memory_vld_out  (vld),
        .memory_data_out (dout)
    );

    always #5 clk = ~clk;

    task automatic chk_data(input string tag, input logic [DW-1:0] expv);
        compared++;
        assert (dout === expv) else begin
            mismatched++;
            $error("FAIL %s: data_out observed %h expected %h", tag, dout, expv);
        end
    endtask

    task automatic chk_vld(input string tag, input logic expv);
        compared++;
        assert (vld === expv) else begin
            mismatched++;
            $error("FAIL %s: vld_out observed %b expected %b", tag, vld, expv);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, update the model at
    // the rising edge, then compare both outputs with the model.
    task automatic op(input string tag, input logic r, input logic e, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst = r; en = e; wr = w; addr = a; din = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            ref_out = '0;
            ref_vld = 1'b0;
        end else if (!e) begin
            ref_out = d;
            ref_vld = 1'b0;
        end else if (w) begin
            ref_mem[a] = d;
            ref_vld = 1'b0;
        end else begin
            ref_out = ref_mem[a];
            ref_vld = 1'b1;
        end
        #1;
        chk_data(tag, ref_out);
        chk_vld(tag, ref_vld);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_out = '0;
        ref_vld = 1'b0;

        // reset after random writes; reads during reset stay at zero
        op("init_rst", 1, 0, 0, 4'h0, 8'h00);
        for (int i = 0; i < 6; i++)
            op("rnd_wr", 0, 1, 1, 4'($urandom_range(0, 15)), 8'($urandom));
        op("rst_rd0", 1, 1, 0, 4'h0, 8'h00);
        chk_data("rst_rd0_const", 8'h00);
        op("rst_rdF", 1, 1, 0, 4'hF, 8'h00);
        chk_vld("rst_rdF_const", 1'b0);
        op("post_rst_rd0", 0, 1, 0, 4'h0, 8'h00);
        chk_data("post_rst_rd0_const", 8'h00);
        chk_vld("post_rst_rd0_vld", 1'b1);
        op("post_rst_rdF", 0, 1, 0, 4'hF, 8'h00);

        // write then read on the next cycle
        op("wr3", 0, 1, 1, 4'h3, 8'hA5);
        chk_vld("wr3_vld", 1'b0);
        op("rd3", 0, 1, 0, 4'h3, 8'h00);
        chk_data("rd3_const", 8'hA5);
        chk_vld("rd3_vld", 1'b1);

        // bypass ignores wr/addr and leaves memory intact
        op("byp", 0, 0, 1, 4'h3, 8'h3C);
        chk_data("byp_const", 8'h3C);
        chk_vld("byp_vld", 1'b0);
        op("rd3_after_byp", 0, 1, 0, 4'h3, 8'h00);
        chk_data("rd3_after_byp_const", 8'hA5);

        // a write holds the output register and drops valid
        op("wr7", 0, 1, 1, 4'h7, 8'h11);
        chk_data("wr7_hold", 8'hA5);
        chk_vld("wr7_vld", 1'b0);

        // full range, back-to-back reads keep valid high
        for (int i = 0; i < DEPTH; i++)
            op("full_wr", 0, 1, 1, 4'(i), 8'(i) ^ 8'hFF);
        for (int i = 0; i < DEPTH; i++) begin
            op("full_rd", 0, 1, 0, 4'(i), 8'h00);
            chk_data("full_rd_const", 8'(i) ^ 8'hFF);
            chk_vld("full_rd_vld", 1'b1);
        end

        // reset in the same cycle as a write drops the write
        op("rst_wr2", 1, 1, 1, 4'h2, 8'h55);
        op("rd2_after_rst", 0, 1, 0, 4'h2, 8'h00);
        chk_data("rd2_after_rst_const", 8'h00);

        // randomized mix with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic r, e, w;
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 4) != 0);
            w = $urandom_range(0, 1) == 1;
            op("rand", r, e, w, 4'($urandom_range(0, 15)), 8'($urandom));
        end

        // final sweep checks that every word still matches the model
        for (int i = 0; i < DEPTH; i++)
            op("sweep", 0, 1, 0, 4'(i), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
